fa_serial_ctrl: RTL and testbench

- Bit-serial add sequencer that time-shares one external 1-bit full adder across WIDTH bit positions, LSB first.
- It accepts a WIDTH-bit operand pair over a valid/ready handshake. It then drives the full adder for WIDTH cycles, holding the carry in a flip-flop between cycles, and returns the WIDTH-bit sum and carry-out over a second valid/ready handshake.
- It is the area-minimal alternative to the ripple-carry array in the adder subsystem.

---
 rtl/fa_serial_ctrl_if.sv | 25 ++
 rtl/fa_serial_ctrl.sv | 94 +++++++++
 tb/tb_fa_serial_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/fa_serial_ctrl_if.sv
// Operand/result handshake bundle for the bit-serial add sequencer.
// The master is the operand source and result consumer. The slave is the sequencer.
interface fa_serial_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum_out;
  logic             cout_out;

  modport master (
    output in_valid, a_in, b_in, cin_in, out_ready,
    input  in_ready, out_valid, sum_out, cout_out
  );

  modport slave (
    input  in_valid, a_in, b_in, cin_in, out_ready,
    output in_ready, out_valid, sum_out, cout_out
  );
endinterface

// File: rtl/fa_serial_ctrl.sv
// Bit-serial adder sequencer: feeds one external full adder LSB first for WIDTH cycles.
// The carry is held in a flip-flop between bit positions.
module fa_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  fa_serial_ctrl_if.slave    bus,
  output logic               busy,
  output logic               fa_a,
  output logic               fa_b,
  output logic               fa_cin,
  input  logic               fa_sum,
  input  logic               fa_cout
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sum_next;

  // The new sum bit enters at the MSB, so after WIDTH shifts bit 0 lands at the LSB.
  assign sum_next = WIDTH'({fa_sum, sum_sh} >> 1);

  assign busy          = (state == RUN);
  assign fa_a          = busy & a_sh[0];
  assign fa_b          = busy & b_sh[0];
  assign fa_cin        = busy & carry;
  assign bus.in_ready  = (state == IDLE) | ((state == DONE) & bus.out_ready);
  assign bus.out_valid = (state == DONE);
  assign bus.sum_out   = sum_reg;
  assign bus.cout_out  = cout_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      sum_sh   <= '0;
      sum_reg  <= '0;
      cout_reg <= 1'b0;
      carry    <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh  <= bus.a_in;
            b_sh  <= bus.b_in;
            carry <= bus.cin_in;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum_sh <= sum_next;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= fa_cout;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            sum_reg  <= sum_next;
            cout_reg <= fa_cout;
            state    <= DONE;
          end
        end
        DONE: begin
          // A result handshake and a new accept may happen on the same edge.
          if (bus.out_ready) begin
            if (bus.in_valid) begin
              a_sh  <= bus.a_in;
              b_sh  <= bus.b_in;
              carry <= bus.cin_in;
              cnt   <= '0;
              state <= RUN;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fa_serial_ctrl.sv
// Scoreboard bench for fa_serial_ctrl: an 8-bit instance for the main tests and a 1-bit instance for the minimum width.
// An ideal full adder closes the loop on each instance.
module tb_fa_serial_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fa_serial_ctrl_if #(.WIDTH(8)) bus8 ();
  fa_serial_ctrl_if #(.WIDTH(1)) bus1 ();

  logic busy8, fa_a8, fa_b8, fa_cin8, fa_sum8, fa_cout8;
  logic busy1, fa_a1, fa_b1, fa_cin1, fa_sum1, fa_cout1;

  assign fa_sum8  = fa_a8 ^ fa_b8 ^ fa_cin8;
  assign fa_cout8 = (fa_a8 & fa_b8) | (fa_a8 & fa_cin8) | (fa_b8 & fa_cin8);
  assign fa_sum1  = fa_a1 ^ fa_b1 ^ fa_cin1;
  assign fa_cout1 = (fa_a1 & fa_b1) | (fa_a1 & fa_cin1) | (fa_b1 & fa_cin1);

  fa_serial_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .bus(bus8), .busy(busy8),
    .fa_a(fa_a8), .fa_b(fa_b8), .fa_cin(fa_cin8), .fa_sum(fa_sum8), .fa_cout(fa_cout8)
  );

  fa_serial_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .busy(busy1),
    .fa_a(fa_a1), .fa_b(fa_b1), .fa_cin(fa_cin1), .fa_sum(fa_sum1), .fa_cout(fa_cout1)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [8:0] q8[$];
  logic [1:0] q1[$];
  bit rand_done;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] model8(input logic [7:0] a, input logic [7:0] b, input logic c);
    return {1'b0, a} + {1'b0, b} + {8'd0, c};
  endfunction

  // Present operands and hold them until the sequencer takes them.
  task automatic apply_stimulus(input logic [7:0] a, input logic [7:0] b, input logic c, input bit push);
    bit acc = 0;
    int n = 0;
    bus8.a_in = a;
    bus8.b_in = b;
    bus8.cin_in = c;
    bus8.in_valid = 1'b1;
    if (push) q8.push_back(model8(a, b, c));
    while (!acc && n < 300) begin
      @(negedge clk);
      #1;
      acc = bus8.in_ready;
      tick();
      n++;
    end
    bus8.in_valid = 1'b0;
    if (!acc) check_output("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    int n = 0;
    while ((q8.size() != 0 || bus8.out_valid || busy8) && n < 300) begin
      tick();
      n++;
    end
    if (n == 300) check_output("drain_timeout", 64'd0, 64'd1);
  endtask

  always @(negedge clk) begin
    if (!rst && bus8.out_valid && bus8.out_ready) begin
      if (q8.size() == 0) check_output("unexpected_result8", {bus8.cout_out, bus8.sum_out}, 64'h1ff);
      else check_output("result8", {bus8.cout_out, bus8.sum_out}, q8.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!rst && bus1.out_valid && bus1.out_ready) begin
      if (q1.size() == 0) check_output("unexpected_result1", {bus1.cout_out, bus1.sum_out}, 64'h7);
      else check_output("result1", {bus1.cout_out, bus1.sum_out}, q1.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] ra, rb;
    logic rc;
    bit seen;
    bus8.in_valid = 0; bus8.a_in = 0; bus8.b_in = 0; bus8.cin_in = 0; bus8.out_ready = 1;
    bus1.in_valid = 0; bus1.a_in = 0; bus1.b_in = 0; bus1.cin_in = 0; bus1.out_ready = 1;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    check_output("reset_in_ready", bus8.in_ready, 1);
    check_output("reset_out_valid", bus8.out_valid, 0);
    check_output("reset_busy", busy8, 0);
    check_output("reset_sum", {bus8.cout_out, bus8.sum_out}, 0);
    check_output("reset_fa", {fa_a8, fa_b8, fa_cin8}, 0);

    // Basic add with the fa_a bit stream checked.
    apply_stimulus(8'h5A, 8'h3C, 1'b0, 1);
    for (int i = 0; i < 8; i++) begin
      check_output("run_busy", busy8, 1);
      check_output("run_in_ready", bus8.in_ready, 0);
      check_output("fa_a_bit", fa_a8, (8'h5A >> i) & 1);
      tick();
    end
    check_output("basic_out_valid", bus8.out_valid, 1);
    check_output("basic_sum", {bus8.cout_out, bus8.sum_out}, 9'h096);
    tick();
    check_output("basic_back_idle", {bus8.in_ready, bus8.out_valid, busy8}, 3'b100);

    // Carry chains.
    apply_stimulus(8'hFF, 8'h01, 1'b0, 1);
    apply_stimulus(8'hFF, 8'h00, 1'b1, 1);
    apply_stimulus(8'h80, 8'h80, 1'b1, 1);
    drain();

    // Backpressure holds the result and blocks new operands.
    bus8.out_ready = 1'b0;
    apply_stimulus(8'h12, 8'h34, 1'b0, 1);
    bus8.a_in = 8'h01; bus8.b_in = 8'h01; bus8.cin_in = 1'b0; bus8.in_valid = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    for (int i = 0; i < 5; i++) begin
      check_output("bp_out_valid", bus8.out_valid, 1);
      check_output("bp_sum", bus8.sum_out, 8'h46);
      check_output("bp_in_ready", bus8.in_ready, 0);
      tick();
    end
    bus8.out_ready = 1'b1;
    apply_stimulus(8'h01, 8'h01, 1'b0, 1);
    check_output("bp_same_edge_accept", {busy8, bus8.out_valid}, 2'b10);
    for (int i = 0; i < 8; i++) tick();
    check_output("bp_second_valid", bus8.out_valid, 1);
    check_output("bp_second_sum", bus8.sum_out, 8'h02);
    drain();

    // Reset mid-operation discards the in-flight add.
    apply_stimulus(8'h55, 8'h66, 1'b0, 0);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_output("midrst_state", {bus8.in_ready, bus8.out_valid, busy8}, 3'b100);
    check_output("midrst_sum", {bus8.cout_out, bus8.sum_out}, 0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus8.out_valid) seen = 1;
      tick();
    end
    check_output("midrst_no_result", seen, 0);
    apply_stimulus(8'h01, 8'h02, 1'b0, 1);
    drain();

    // Random stream with input gaps and output stalls.
    rand_done = 0;
    fork
      begin
        for (int k = 0; k < 200; k++) begin
          ra = 8'($urandom);
          rb = 8'($urandom);
          rc = 1'($urandom);
          repeat ($urandom_range(0, 2)) tick();
          apply_stimulus(ra, rb, rc, 1);
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          bus8.out_ready = ($urandom_range(0, 3) != 0);
          tick();
        end
        bus8.out_ready = 1'b1;
      end
    join
    drain();
    check_output("stream_queue_empty", q8.size(), 0);

    // Minimum width: one RUN cycle.
    q1.push_back(2'b11);
    bus1.a_in = 1'b1; bus1.b_in = 1'b1; bus1.cin_in = 1'b1; bus1.in_valid = 1'b1;
    check_output("w1_in_ready", bus1.in_ready, 1);
    tick();
    bus1.in_valid = 1'b0;
    check_output("w1_busy", busy1, 1);
    check_output("w1_fa", {fa_a1, fa_b1, fa_cin1}, 3'b111);
    tick();
    check_output("w1_out_valid", bus1.out_valid, 1);
    check_output("w1_sum", {bus1.cout_out, bus1.sum_out}, 2'b11);
    tick();
    check_output("w1_idle", {bus1.in_ready, bus1.out_valid}, 2'b10);
    check_output("w1_queue_empty", q1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
